// File: rtl/div16_seq_pkg.sv
// Shared constants for the sequential divider: operand width, FSM encoding
// and the quotient reported on a divide-by-zero.
package div16_seq_pkg;

  // Fixed by the 16-bit carry-lookahead adder used as the trial subtractor.
  localparam int unsigned WIDTH = 16;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [WIDTH-1:0] DIV0_QUOTIENT = 16'hFFFF;

endpackage

// File: rtl/cla16.sv
// 16-bit carry-lookahead adder: four 4-bit groups with group generate/propagate
// and a lookahead carry chain across the groups.
module cla16 (
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  input  logic        cin_i,
  output logic [15:0] sum_o,
  output logic        cout_o
);

  logic [15:0] g;
  logic [15:0] p;
  logic [3:0]  grp_g;
  logic [3:0]  grp_p;
  logic [4:0]  grp_c;

  assign g = a_i & b_i;
  assign p = a_i ^ b_i;

  // Group generate/propagate terms.
  always_comb begin
    grp_g = '0;
    grp_p = '0;
    for (int k = 0; k < 4; k++) begin
      grp_p[k] = &p[4*k +: 4];
      grp_g[k] = g[4*k+3]
               | (p[4*k+3] & g[4*k+2])
               | (p[4*k+3] & p[4*k+2] & g[4*k+1])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
    end
  end

  // Lookahead carries into each group, expanded so no carry depends on another.
  always_comb begin
    grp_c    = '0;
    grp_c[0] = cin_i;
    grp_c[1] = grp_g[0] | (grp_p[0] & cin_i);
    grp_c[2] = grp_g[1] | (grp_p[1] & grp_g[0]) | (grp_p[1] & grp_p[0] & cin_i);
    grp_c[3] = grp_g[2] | (grp_p[2] & grp_g[1]) | (grp_p[2] & grp_p[1] & grp_g[0])
             | (grp_p[2] & grp_p[1] & grp_p[0] & cin_i);
    grp_c[4] = grp_g[3] | (grp_p[3] & grp_g[2]) | (grp_p[3] & grp_p[2] & grp_g[1])
             | (grp_p[3] & grp_p[2] & grp_p[1] & grp_g[0])
             | (grp_p[3] & grp_p[2] & grp_p[1] & grp_p[0] & cin_i);
  end

  // Sum bits: short in-group carry chain seeded by the lookahead carry.
  always_comb begin
    logic carry;
    sum_o = '0;
    carry = 1'b0;
    for (int k = 0; k < 4; k++) begin
      carry = grp_c[k];
      for (int j = 0; j < 4; j++) begin
        sum_o[4*k+j] = p[4*k+j] ^ carry;
        carry        = g[4*k+j] | (p[4*k+j] & carry);
      end
    end
  end

  assign cout_o = grp_c[4];

endmodule

// File: rtl/div16_seq.sv
// Sequential 16-bit unsigned restoring divider. One trial subtraction per
// clock through cla16 (A + ~B + 1), framed by a start/done handshake.
module div16_seq
  import div16_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  logic [1:0]       state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [WIDTH-1:0] v_q, v_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             dz_q, dz_d;

  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic             diff_cout;
  logic             success;

  // Partial remainder shifted left with the next dividend bit; bit 16 only
  // feeds the success decision since R < V keeps the result within 16 bits.
  assign shifted = {r_q, d_q[WIDTH-1]};

  cla16 u_sub (
    .a_i    (shifted[WIDTH-1:0]),
    .b_i    (~v_q),
    .cin_i  (1'b1),
    .sum_o  (diff),
    .cout_o (diff_cout)
  );

  assign success = shifted[WIDTH] | diff_cout;

  // Next-state logic for the FSM and datapath registers.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    d_d     = d_q;
    v_d     = v_q;
    r_d     = r_q;
    q_d     = q_q;
    dz_d    = dz_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (divisor == '0) begin
            q_d     = DIV0_QUOTIENT;
            r_d     = dividend;
            dz_d    = 1'b1;
            state_d = DONE;
          end else begin
            d_d     = dividend;
            v_d     = divisor;
            r_d     = '0;
            q_d     = '0;
            dz_d    = 1'b0;
            cnt_d   = 4'd15;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        r_d = success ? diff : shifted[WIDTH-1:0];
        q_d = {q_q[WIDTH-2:0], success};
        d_d = {d_q[WIDTH-2:0], 1'b0};
        if (cnt_q == 4'd0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers; reset discards any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      d_q     <= '0;
      v_q     <= '0;
      r_q     <= '0;
      q_q     <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      d_q     <= d_d;
      v_q     <= v_d;
      r_q     <= r_d;
      q_q     <= q_d;
      dz_q    <= dz_d;
    end
  end

  assign quotient    = q_q;
  assign remainder   = r_q;
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign div_by_zero = dz_q;

endmodule

// File: tb/tb_div16_seq.sv
// Directed self-checking bench for div16_seq.
module tb_div16_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] dividend;
  logic [15:0] divisor;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        busy;
  logic        done;
  logic        div_by_zero;

  int errors = 0;
  int checks = 0;

  div16_seq dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one request from IDLE and wait for done. lat counts edges from the
  // accepting edge up to the cycle in which done is seen (17 normal, 1 div0).
  task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                        output logic [15:0] q, output logic [15:0] r,
                        output logic dz, output int lat, output int busy_cnt);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    step();
    start    = 1'b0;
    lat      = 1;
    busy_cnt = 0;
    while (!done && lat < 40) begin
      if (busy) busy_cnt++;
      step();
      lat++;
    end
    if (busy) busy_cnt++;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL op_timeout %0d/%0d: done=%b after %0d cycles, required 1", a, b, done, lat);
    end
    q  = quotient;
    r  = remainder;
    dz = div_by_zero;
    step();
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    step();
    step();
    if (quotient !== 16'd0) begin errors++; $display("FAIL reset_quotient got %h want 0000", quotient); end
    checks++;
    if (remainder !== 16'd0) begin errors++; $display("FAIL reset_remainder got %h want 0000", remainder); end
    checks++;
    if ({busy, done, div_by_zero} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags got busy/done/dz=%b%b%b want 000", busy, done, div_by_zero);
    end
    checks++;
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic();
    logic [15:0] q, r;
    logic dz;
    int lat, bc;
    run_op(16'd100, 16'd7, q, r, dz, lat, bc);
    if (q !== 16'd14) begin errors++; $display("FAIL basic_quotient got %0d want 14", q); end
    checks++;
    if (r !== 16'd2) begin errors++; $display("FAIL basic_remainder got %0d want 2", r); end
    checks++;
    if (dz !== 1'b0) begin errors++; $display("FAIL basic_dz got %b want 0", dz); end
    checks++;
    if (lat != 17) begin errors++; $display("FAIL basic_latency got %0d want 17", lat); end
    checks++;
    if (bc != 17) begin errors++; $display("FAIL basic_busy_cycles got %0d want 17", bc); end
    checks++;
    // One cycle after done: back in IDLE, results held.
    if ({done, busy} !== 2'b00) begin
      errors++;
      $display("FAIL basic_done_pulse got done/busy=%b%b want 00", done, busy);
    end
    checks++;
    step();
    step();
    if (quotient !== 16'd14 || remainder !== 16'd2) begin
      errors++;
      $display("FAIL basic_hold got q=%0d r=%0d want q=14 r=2", quotient, remainder);
    end
    checks++;
  endtask

  task automatic test_edges();
    logic [15:0] q, r;
    logic dz;
    int lat, bc;
    run_op(16'hFFFF, 16'h8000, q, r, dz, lat, bc);
    if (q !== 16'd1 || r !== 16'h7FFF) begin
      errors++;
      $display("FAIL ffff_div_8000 got q=%h r=%h want q=0001 r=7fff", q, r);
    end
    checks++;
    run_op(16'h8000, 16'hFFFF, q, r, dz, lat, bc);
    if (q !== 16'd0 || r !== 16'h8000) begin
      errors++;
      $display("FAIL 8000_div_ffff got q=%h r=%h want q=0000 r=8000", q, r);
    end
    checks++;
    run_op(16'hFFFF, 16'd1, q, r, dz, lat, bc);
    if (q !== 16'hFFFF || r !== 16'd0) begin
      errors++;
      $display("FAIL ffff_div_1 got q=%h r=%h want q=ffff r=0000", q, r);
    end
    checks++;
    run_op(16'd0, 16'd5, q, r, dz, lat, bc);
    if (q !== 16'd0 || r !== 16'd0) begin
      errors++;
      $display("FAIL 0_div_5 got q=%h r=%h want q=0000 r=0000", q, r);
    end
    checks++;
  endtask

  task automatic test_div_zero();
    logic [15:0] q, r;
    logic dz;
    int lat, bc;
    run_op(16'd5, 16'd0, q, r, dz, lat, bc);
    if (dz !== 1'b1) begin errors++; $display("FAIL div0_flag got %b want 1", dz); end
    checks++;
    if (q !== 16'hFFFF || r !== 16'd5) begin
      errors++;
      $display("FAIL div0_result got q=%h r=%h want q=ffff r=0005", q, r);
    end
    checks++;
    if (lat != 1) begin errors++; $display("FAIL div0_latency got %0d want 1", lat); end
    checks++;
    if (div_by_zero !== 1'b1) begin errors++; $display("FAIL div0_hold got %b want 1", div_by_zero); end
    checks++;
    run_op(16'd9, 16'd3, q, r, dz, lat, bc);
    if (dz !== 1'b0 || q !== 16'd3 || r !== 16'd0) begin
      errors++;
      $display("FAIL after_div0 got dz=%b q=%0d r=%0d want dz=0 q=3 r=0", dz, q, r);
    end
    checks++;
  endtask

  // A second start pulse mid-operation must not disturb the running one.
  task automatic test_ignored_start();
    int lat;
    dividend = 16'd1000;
    divisor  = 16'd10;
    start    = 1'b1;
    step();
    start = 1'b0;
    lat   = 1;
    while (!done && lat < 40) begin
      if (lat == 5) begin
        dividend = 16'd7;
        divisor  = 16'd7;
        start    = 1'b1;
      end else begin
        start = 1'b0;
      end
      step();
      lat++;
    end
    start = 1'b0;
    if (lat != 17) begin errors++; $display("FAIL ignored_start_latency got %0d want 17", lat); end
    checks++;
    if (quotient !== 16'd100 || remainder !== 16'd0) begin
      errors++;
      $display("FAIL ignored_start_result got q=%0d r=%0d want q=100 r=0", quotient, remainder);
    end
    checks++;
    step();
    step();
    if (busy !== 1'b0) begin errors++; $display("FAIL ignored_start_not_queued got busy=%b want 0", busy); end
    checks++;
  endtask

  task automatic test_mid_reset();
    logic [15:0] q, r;
    logic dz;
    int lat, bc;
    int done_seen;
    dividend = 16'd500;
    divisor  = 16'd3;
    start    = 1'b1;
    step();
    start = 1'b0;
    for (int i = 1; i < 8; i++) step();
    #2;
    rst = 1'b1;
    #1;
    if (quotient !== 16'd0 || remainder !== 16'd0 || {busy, done, div_by_zero} !== 3'b000) begin
      errors++;
      $display("FAIL mid_reset_async got q=%h r=%h busy/done/dz=%b%b%b want all zero",
               quotient, remainder, busy, done, div_by_zero);
    end
    checks++;
    step();
    rst       = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) done_seen++;
      step();
    end
    if (done_seen != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_no_done got done_count=%0d busy=%b want 0 0", done_seen, busy);
    end
    checks++;
    run_op(16'd500, 16'd3, q, r, dz, lat, bc);
    if (q !== 16'd166 || r !== 16'd2) begin
      errors++;
      $display("FAIL mid_reset_rerun got q=%0d r=%0d want q=166 r=2", q, r);
    end
    checks++;
  endtask

  // run_op returns in the IDLE cycle after DONE, so this start is the
  // earliest one accepted.
  task automatic test_back_to_back();
    logic [15:0] q, r;
    logic dz;
    int lat, bc;
    run_op(16'd40, 16'd0, q, r, dz, lat, bc);
    run_op(16'd12, 16'd5, q, r, dz, lat, bc);
    if (q !== 16'd2 || r !== 16'd2 || dz !== 1'b0 || lat != 17) begin
      errors++;
      $display("FAIL back_to_back got q=%0d r=%0d dz=%b lat=%0d want q=2 r=2 dz=0 lat=17",
               q, r, dz, lat);
    end
    checks++;
    run_op(16'd65535, 16'd255, q, r, dz, lat, bc);
    if (q !== 16'd257 || r !== 16'd0) begin
      errors++;
      $display("FAIL back_to_back_2 got q=%0d r=%0d want q=257 r=0", q, r);
    end
    checks++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_edges();
    test_div_zero();
    test_ignored_start();
    test_mid_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
